// File: rtl/conv_core_pkg.sv
// Shared types and defaults for the conv core sequencer family.
// State encoding and kernel geometry used by conv_core_sched and its fetch unit.
package conv_core_pkg;

    localparam int WIDTH = 8;
    localparam int KTAPS = 9;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOADW  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/conv_weight_fetch.sv
// Weight fetch unit: issues KTAPS consecutive buffer reads from a base address
// and re-times them into a load strobe that lines up with the read data.
module conv_weight_fetch #(
    parameter int WADDR_W = 10,
    parameter int KTAPS   = conv_core_pkg::KTAPS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               kill,
    input  logic [WADDR_W-1:0] base,
    output logic               ren,
    output logic [WADDR_W-1:0] raddr,
    output logic               load,
    output logic               tap_done
);

    localparam int TAP_W = $clog2(KTAPS + 1);

    logic [TAP_W-1:0] tap_cnt;
    logic             load_p1;

    assign ren      = en & ~kill & (tap_cnt < TAP_W'(KTAPS));
    assign raddr    = ren ? base + WADDR_W'(tap_cnt) : '0;
    // A kill in the strobe cycle also swallows the pending delayed strobe.
    assign load     = load_p1 & ~kill;
    assign tap_done = load & (tap_cnt == TAP_W'(KTAPS));

    always_ff @(posedge clk) begin
        if (rst || clr || kill) begin
            tap_cnt <= '0;
        end else if (ren) begin
            tap_cnt <= tap_cnt + TAP_W'(1);
        end
    end

    // p0 -> p1: read issue to read data valid
    always_ff @(posedge clk) begin
        if (rst) begin
            load_p1 <= 1'b0;
        end else begin
            load_p1 <= ren;
        end
    end

endmodule

// File: rtl/conv_core_sched.sv
// Per-tile sequencer for a 4-filter 3x3 core: weight load, activation stream, psum drain.
// Optional perf counters are built when CONV_CORE_SCHED_PERF_EN is defined.
module conv_core_sched
    import conv_core_pkg::*;
#(
    parameter int WIDTH   = conv_core_pkg::WIDTH,
    parameter int WADDR_W = 10,
    parameter int CNT_W   = 16,
    parameter int KTAPS   = conv_core_pkg::KTAPS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WADDR_W-1:0] cfg_wbase,
    input  logic [CNT_W-1:0]   cfg_num_act,
    input  logic [CNT_W-1:0]   cfg_num_psum,
    output logic               busy,
    output logic               done,
    output logic               wbuf_ren,
    output logic [WADDR_W-1:0] wbuf_raddr,
    output logic               core_weight_load,
    input  logic               core_weight_load_done,
    input  logic               afifo_empty,
    output logic               core_activate_ready,
    input  logic               core_psum_vld,
    output logic               out_wen,
    output logic [CNT_W-1:0]   out_waddr
`ifdef CONV_CORE_SCHED_PERF_EN
    ,
    output logic [CNT_W-1:0]   perf_stall_cyc,
    output logic [CNT_W-1:0]   perf_pass_cyc
`endif
);

    // Lane width only matters to the core; the load-done flag is redundant with
    // the local tap counter, which alone decides when loading is over.
    localparam int unused_width = WIDTH;
    logic unused_load_done;
    assign unused_load_done = core_weight_load_done;

    state_t state, state_nxt;

    logic [WADDR_W-1:0] wbase_r;
    logic [CNT_W-1:0]   num_act_r;
    logic [CNT_W-1:0]   num_psum_r;
    logic [CNT_W-1:0]   act_cnt;
    logic [CNT_W-1:0]   psum_cnt;
    logic [CNT_W-1:0]   act_nxt;
    logic [CNT_W:0]     psum_nxt;

    logic kill;
    logic start_acc;
    logic fetch_en;
    logic tap_done;
    logic act_left;
    logic ready;
    logic wen;

    assign kill      = rst | abort;
    assign start_acc = (state == S_IDLE) & start & ~kill;
    assign fetch_en  = (state == S_LOADW);
    assign act_left  = act_cnt < num_act_r;
    assign ready     = (state == S_STREAM) & ~afifo_empty & act_left & ~kill;
    assign wen       = ((state == S_STREAM) | (state == S_DRAIN)) & core_psum_vld & ~kill;
    assign act_nxt   = act_cnt + CNT_W'(ready);
    assign psum_nxt  = {1'b0, psum_cnt} + (CNT_W + 1)'(wen);

    conv_weight_fetch #(
        .WADDR_W (WADDR_W),
        .KTAPS   (KTAPS)
    ) u_fetch (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_acc),
        .en       (fetch_en),
        .kill     (kill),
        .base     (wbase_r),
        .ren      (wbuf_ren),
        .raddr    (wbuf_raddr),
        .load     (core_weight_load),
        .tap_done (tap_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN uses >= so psums completed during STREAM still give one DRAIN cycle.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (start) state_nxt = S_LOADW;
                S_LOADW:  if (tap_done) state_nxt = (num_act_r == '0) ? S_DRAIN : S_STREAM;
                S_STREAM: if (act_nxt == num_act_r) state_nxt = S_DRAIN;
                S_DRAIN:  if (psum_nxt >= {1'b0, num_psum_r}) state_nxt = S_DONE;
                S_DONE:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (start_acc) begin
            wbase_r    <= cfg_wbase;
            num_act_r  <= cfg_num_act;
            num_psum_r <= cfg_num_psum;
        end
    end

    always_ff @(posedge clk) begin
        if (kill || start_acc) begin
            act_cnt  <= '0;
            psum_cnt <= '0;
        end else begin
            if (ready) act_cnt <= act_nxt;
            if (wen)   psum_cnt <= psum_nxt[CNT_W-1:0];
        end
    end

    assign busy                = (state != S_IDLE);
    assign done                = (state == S_DONE) & ~kill;
    assign core_activate_ready = ready;
    assign out_wen             = wen;
    assign out_waddr           = psum_cnt;

`ifdef CONV_CORE_SCHED_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Counters freeze outside a pass so software can read them after done.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            perf_stall_cyc <= '0;
            perf_pass_cyc  <= '0;
        end else begin
            if ((state == S_STREAM) && afifo_empty && act_left)
                perf_stall_cyc <= sat_inc(perf_stall_cyc);
            if ((state == S_LOADW) || (state == S_STREAM) || (state == S_DRAIN))
                perf_pass_cyc <= sat_inc(perf_pass_cyc);
        end
    end
`endif

endmodule

// File: tb/tb_conv_core_sched.sv
// Directed bench for conv_core_sched with a cycle-level reference model and
// per-test hand-computed expectations; perf ports checked when the macro is set.
module tb_conv_core_sched;

    localparam int WADDR_W = 10;
    localparam int CNT_W   = 16;
    localparam int PH_LOAD = 0, PH_STREAM = 1, PH_DRAIN = 2, PH_DONE = 3;

    logic               clk = 1'b0;
    logic               rst, start, abort, afifo_empty, core_psum_vld;
    logic               core_weight_load_done;
    logic [WADDR_W-1:0] cfg_wbase;
    logic [CNT_W-1:0]   cfg_num_act, cfg_num_psum;
    logic               busy, done, wbuf_ren, core_weight_load, core_activate_ready, out_wen;
    logic [WADDR_W-1:0] wbuf_raddr;
    logic [CNT_W-1:0]   out_waddr;
`ifdef CONV_CORE_SCHED_PERF_EN
    logic [CNT_W-1:0]   perf_stall_cyc, perf_pass_cyc;
`endif

    conv_core_sched #(.WIDTH(8), .WADDR_W(WADDR_W), .CNT_W(CNT_W), .KTAPS(9)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .abort                 (abort),
        .cfg_wbase             (cfg_wbase),
        .cfg_num_act           (cfg_num_act),
        .cfg_num_psum          (cfg_num_psum),
        .busy                  (busy),
        .done                  (done),
        .wbuf_ren              (wbuf_ren),
        .wbuf_raddr            (wbuf_raddr),
        .core_weight_load      (core_weight_load),
        .core_weight_load_done (core_weight_load_done),
        .afifo_empty           (afifo_empty),
        .core_activate_ready   (core_activate_ready),
        .core_psum_vld         (core_psum_vld),
        .out_wen               (out_wen),
        .out_waddr             (out_waddr)
`ifdef CONV_CORE_SCHED_PERF_EN
        ,
        .perf_stall_cyc        (perf_stall_cyc),
        .perf_pass_cyc         (perf_pass_cyc)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // Cumulative event log kept by the monitor; tests look at deltas.
    int cyc = 0;
    int tot_strobe = 0, tot_ready = 0, tot_wen = 0, tot_done = 0, last_done_cyc = -1;
    int ready_while_empty = 0, ready_while_load = 0;
    logic [WADDR_W-1:0] raddr_q[$];
    logic [CNT_W-1:0]   waddr_q[$];
    int b_cyc, b_strobe, b_ready, b_wen, b_done, b_raddr, b_waddr;
    bit chk_en = 1'b0;

    // Core model: flags weight index 8 on the ninth strobe of the current load.
    assign core_weight_load_done = core_weight_load && ((tot_strobe - b_strobe) == 8);

    // Reference model state
    bit                 m_active = 1'b0;
    int                 m_t = 0, m_ph = PH_LOAD;
    logic [WADDR_W-1:0] m_base = '0;
    int                 m_nact = 0, m_npsum = 0, m_acts = 0, m_psums = 0;

    always @(negedge clk) begin
        bit kill;
        bit e_ren, e_load, e_ready, e_wen, e_done;
        logic [WADDR_W-1:0] e_raddr;
        kill = rst | abort;
        e_ren = 0; e_load = 0; e_ready = 0; e_wen = 0; e_done = 0; e_raddr = '0;
        if (m_active && !kill) begin
            if (m_ph == PH_LOAD) begin
                e_ren   = (m_t <= 9);
                e_raddr = m_base + WADDR_W'(m_t - 1);
                e_load  = (m_t >= 2);
            end
            if (m_ph == PH_STREAM) e_ready = !afifo_empty && (m_acts < m_nact);
            if (m_ph == PH_STREAM || m_ph == PH_DRAIN) e_wen = core_psum_vld;
            if (m_ph == PH_DONE) e_done = 1'b1;
        end
        if (chk_en) begin
            chk("busy", busy, m_active);
            chk("wbuf_ren", wbuf_ren, e_ren);
            if (e_ren) chk("wbuf_raddr", wbuf_raddr, e_raddr);
            chk("core_weight_load", core_weight_load, e_load);
            chk("core_activate_ready", core_activate_ready, e_ready);
            chk("out_wen", out_wen, e_wen);
            chk("out_waddr", out_waddr, m_psums);
            chk("done", done, e_done);
        end
        if (kill) begin
            m_active = 1'b0; m_acts = 0; m_psums = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_t = 1; m_ph = PH_LOAD; m_base = cfg_wbase;
                m_nact = int'(cfg_num_act); m_npsum = int'(cfg_num_psum);
                m_acts = 0; m_psums = 0;
            end
        end else begin
            if (e_ready) m_acts++;
            if (e_wen) m_psums++;
            case (m_ph)
                PH_LOAD:   if (m_t == 10) m_ph = (m_nact == 0) ? PH_DRAIN : PH_STREAM;
                           else m_t++;
                PH_STREAM: if (m_acts == m_nact) m_ph = PH_DRAIN;
                PH_DRAIN:  if (m_psums >= m_npsum) m_ph = PH_DONE;
                default:   m_active = 1'b0;
            endcase
        end
        if (wbuf_ren) raddr_q.push_back(wbuf_raddr);
        if (core_weight_load) tot_strobe++;
        if (core_activate_ready) tot_ready++;
        if (core_activate_ready && afifo_empty) ready_while_empty++;
        if (core_activate_ready && core_weight_load) ready_while_load++;
        if (out_wen) begin tot_wen++; waddr_q.push_back(out_waddr); end
        if (done) begin tot_done++; last_done_cyc = cyc; end
        cyc++;
    end

    // Cycle c of a pass is relative to the start pulse (c = 0).
    task automatic run_pass(input logic [WADDR_W-1:0] wb, input int na, input int np,
                            input logic [63:0] emask, input logic [63:0] vmask,
                            input int abort_cyc, input int restart_cyc, input int rst_cyc,
                            input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) begin
                b_cyc = cyc; b_strobe = tot_strobe; b_ready = tot_ready; b_wen = tot_wen;
                b_done = tot_done; b_raddr = raddr_q.size(); b_waddr = waddr_q.size();
            end
            start = (c == 0) || (c == restart_cyc);
            if (c == 0) begin
                cfg_wbase = wb; cfg_num_act = CNT_W'(na); cfg_num_psum = CNT_W'(np);
            end else if (c == restart_cyc) begin
                cfg_wbase = 10'h055; cfg_num_act = 16'd7; cfg_num_psum = 16'd9;
            end else begin
                cfg_wbase = 10'h3AB; cfg_num_act = 16'd99; cfg_num_psum = 16'd77;
            end
            abort = (c == abort_cyc);
            rst = (c == rst_cyc);
            afifo_empty = emask[c];
            core_psum_vld = vmask[c];
            @(posedge clk);
            #1;
        end
        start = 0; abort = 0; rst = 0; afifo_empty = 0; core_psum_vld = 0;
    endtask

    function automatic int done_rel();
        return last_done_cyc - b_cyc;
    endfunction

    initial begin
        logic [WADDR_W-1:0] wrap_exp [9];
        wrap_exp = '{10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002, 10'h003, 10'h004};
        rst = 1; start = 0; abort = 0; afifo_empty = 0; core_psum_vld = 0;
        cfg_wbase = '0; cfg_num_act = '0; cfg_num_psum = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ren", wbuf_ren, 0);
        chk("rst_load", core_weight_load, 0);
        chk("rst_ready", core_activate_ready, 0);
        chk("rst_wen", out_wen, 0);
        chk("rst_waddr", out_waddr, 0);
        rst = 0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Nominal pass
        run_pass(10'h100, 4, 2, 64'h0, (64'b1 << 17) | (64'b1 << 18), -1, -1, -1, 24);
        chk("nom_nreads", raddr_q.size() - b_raddr, 9);
        if (raddr_q.size() >= b_raddr + 9)
            for (int i = 0; i < 9; i++) chk("nom_raddr", raddr_q[b_raddr + i], 10'h100 + i);
        chk("nom_strobes", tot_strobe - b_strobe, 9);
        chk("nom_readies", tot_ready - b_ready, 4);
        chk("nom_nwrites", waddr_q.size() - b_waddr, 2);
        if (waddr_q.size() >= b_waddr + 2) begin
            chk("nom_waddr0", waddr_q[b_waddr], 0);
            chk("nom_waddr1", waddr_q[b_waddr + 1], 1);
        end
        chk("nom_dones", tot_done - b_done, 1);
        chk("nom_done_cyc", done_rel(), 19);
`ifdef CONV_CORE_SCHED_PERF_EN
        chk("nom_perf_stall", perf_stall_cyc, 0);
        chk("nom_perf_pass", perf_pass_cyc, 18);
`endif

        // FIFO empty for 3 cycles mid-stream
        run_pass(10'h000, 4, 1, 64'b111 << 12, 64'b1 << 20, -1, -1, -1, 26);
        chk("stall_readies", tot_ready - b_ready, 4);
        chk("stall_ready_empty", ready_while_empty, 0);
        chk("stall_dones", tot_done - b_done, 1);
        chk("stall_done_cyc", done_rel(), 21);
`ifdef CONV_CORE_SCHED_PERF_EN
        chk("stall_perf_stall", perf_stall_cyc, 3);
        chk("stall_perf_pass", perf_pass_cyc, 20);
`endif

        // Zero counts; psum valids outside STREAM/DRAIN are ignored
        run_pass(10'h080, 0, 0, 64'h0, (64'b1 << 5) | (64'b1 << 13), -1, -1, -1, 18);
        chk("zero_strobes", tot_strobe - b_strobe, 9);
        chk("zero_readies", tot_ready - b_ready, 0);
        chk("zero_wen", tot_wen - b_wen, 0);
        chk("zero_dones", tot_done - b_done, 1);
        chk("zero_done_cyc", done_rel(), 12);
`ifdef CONV_CORE_SCHED_PERF_EN
        chk("zero_perf_pass", perf_pass_cyc, 11);
`endif

        // Abort right after the 5th strobe, then a fresh pass
        run_pass(10'h200, 4, 2, 64'h0, 64'h0, 7, -1, -1, 14);
        chk("abort_strobes", tot_strobe - b_strobe, 5);
        chk("abort_nreads", raddr_q.size() - b_raddr, 6);
        chk("abort_dones", tot_done - b_done, 0);
        chk("abort_busy", busy, 0);
        run_pass(10'h010, 2, 2, 64'h0, (64'b1 << 13) | (64'b1 << 14), -1, -1, -1, 20);
        chk("reload_strobes", tot_strobe - b_strobe, 9);
        if (raddr_q.size() >= b_raddr + 9) begin
            chk("reload_raddr_first", raddr_q[b_raddr], 10'h010);
            chk("reload_raddr_last", raddr_q[b_raddr + 8], 10'h018);
        end
        chk("reload_done_cyc", done_rel(), 15);

        // Address wrap plus a start pulse while busy
        run_pass(10'h3FC, 1, 1, 64'h0, 64'b1 << 12, -1, 5, -1, 18);
        chk("wrap_nreads", raddr_q.size() - b_raddr, 9);
        if (raddr_q.size() >= b_raddr + 9)
            for (int i = 0; i < 9; i++) chk("wrap_raddr", raddr_q[b_raddr + i], wrap_exp[i]);
        chk("busy_start_readies", tot_ready - b_ready, 1);
        chk("wrap_dones", tot_done - b_done, 1);
        chk("wrap_done_cyc", done_rel(), 13);

        // Back-to-back psums spanning STREAM and DRAIN
        run_pass(10'h020, 3, 8, 64'h0, 64'hFF << 12, -1, -1, -1, 26);
        chk("b2b_nwrites", waddr_q.size() - b_waddr, 8);
        if (waddr_q.size() >= b_waddr + 8)
            for (int i = 0; i < 8; i++) chk("b2b_waddr", waddr_q[b_waddr + i], i);
        chk("b2b_dones", tot_done - b_done, 1);
        chk("b2b_done_cyc", done_rel(), 20);

        // Reset in the middle of streaming
        run_pass(10'h040, 4, 5, 64'h0, 64'h0, -1, -1, 13, 18);
        chk("rstmid_readies", tot_ready - b_ready, 2);
        chk("rstmid_dones", tot_done - b_done, 0);
        chk("rstmid_waddr", out_waddr, 0);

        chk("ready_during_load", ready_while_load, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
